mcp_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one multi-cycle-path CDC transmit channel between `N_REQ` requesters in the source clock domain. It accepts a word from one requester at a time and drives it onto the channel. It issues a single launch pulse when the channel reports ready, then holds the word stable for `HOLD_CYCLES` source cycles so the destination synchronizer can sample it safely. Only after the hold does it grant the next requester.

---
 rtl/mcp_arb_pkg.sv | 18 +
 rtl/mcp_tx_arbiter_rr_pick.sv | 41 ++++
 rtl/mcp_tx_arbiter.sv | 113 +++++++++++
 tb/tb_mcp_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_arb_pkg.sv
// Shared definitions for the multi-cycle-path transmit arbiter and its channel block.
package mcp_arb_pkg;

  localparam int MCP_DATA_W      = 32;
  localparam int MCP_HOLD_CYCLES = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    HOLD     = 2'd2
  } mcp_arb_state_t;

  // Index/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcp_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req at or above ptr, wrapping.
module rr_pick
  import mcp_arb_pkg::*;
#(
  parameter int  N_REQ = 4,
  localparam int IW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx,
  output logic [N_REQ-1:0] onehot
);

  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW:0]        sum;

  // Doubling req lets a plain shift perform the wrap-around rotation.
  assign req_dbl = {req, req};
  assign rot     = N_REQ'(req_dbl >> ptr);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (IW+1)'(i);
        if (sum >= N_W) sum = sum - N_W;
        idx   = sum[IW-1:0];
      end
    end
  end

  assign onehot = valid ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mcp_tx_arbiter.sv
// Round-robin scheduler feeding one multi-cycle-path CDC transmit channel:
// grant, launch on ready, then freeze the word for HOLD_CYCLES before the next grant.
module mcp_tx_arbiter
  import mcp_arb_pkg::*;
#(
  parameter int  N_REQ       = 4,
  parameter int  DATA_W      = MCP_DATA_W,
  parameter int  HOLD_CYCLES = MCP_HOLD_CYCLES,
  localparam int IW          = clog2_min1(N_REQ),
  localparam int HW          = clog2_min1(HOLD_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  input  logic                    ch_ready,
  output logic [DATA_W-1:0]       ch_data,
  output logic                    ch_launch,
  output logic [IW-1:0]           grant_id,
  output logic                    busy
);

  mcp_arb_state_t state_q, state_d;

  logic [IW-1:0]     ptr_q, ptr_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [IW-1:0]     gid_d;
  logic [DATA_W-1:0] data_d;
  logic [N_REQ-1:0]  ack_d;
  logic              launch_d;

  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [N_REQ-1:0]  pick_onehot;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IW'(k)) sel_data = req_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gid_d    = grant_id;
    data_d   = ch_data;
    ack_d    = '0;
    launch_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_valid) begin
          data_d  = sel_data;
          gid_d   = pick_idx;
          ack_d   = pick_onehot;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (ch_ready) begin
          launch_d = 1'b1;
          hold_d   = HW'(HOLD_CYCLES - 1);
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // Pointer only advances once the word has been safely held.
        if (hold_q == '0) begin
          state_d = IDLE;
          ptr_d   = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_id  <= '0;
      ch_data   <= '0;
      ack       <= '0;
      ch_launch <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_id  <= gid_d;
      ch_data   <= data_d;
      ack       <= ack_d;
      ch_launch <= launch_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mcp_tx_arbiter.sv
// Self-checking bench for mcp_tx_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mcp_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int HC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, ch_ready;
  logic [N-1:0]  req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  ack;
  logic [DW-1:0] ch_data;
  logic          ch_launch;
  logic [1:0]    grant_id;
  logic          busy;

  logic          en_b, ready_b;
  logic [0:0]    req_b, ack_b, gid_b;
  logic [DW-1:0] data_b, ch_data_b;
  logic          launch_b, busy_b;

  mcp_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_data(req_data), .ack(ack),
    .ch_ready(ch_ready), .ch_data(ch_data), .ch_launch(ch_launch),
    .grant_id(grant_id), .busy(busy)
  );

  mcp_tx_arbiter #(.N_REQ(1), .DATA_W(DW), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .req(req_b), .req_data(data_b), .ack(ack_b),
    .ch_ready(ready_b), .ch_data(ch_data_b), .ch_launch(launch_b),
    .grant_id(gid_b), .busy(busy_b)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: transfer bookkeeping in terms of remaining hold cycles.
  bit          m_busy, m_wait;
  int          m_hold, m_ptr, m_gid;
  logic [DW-1:0] m_data;
  logic [N-1:0]  e_ack;
  bit          e_launch;

  task automatic tick();
    int k;
    @(posedge clk);
    cyc++;
    e_ack = '0;
    e_launch = 1'b0;
    if (rst) begin
      m_busy = 0; m_wait = 0; m_hold = 0; m_ptr = 0; m_gid = 0; m_data = '0;
    end else if (!m_busy) begin
      if (en && req != '0) begin
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (req[k]) begin
            m_gid = k;
            m_data = req_data[k*DW +: DW];
            e_ack = N'(1) << k;
            m_busy = 1; m_wait = 1;
            break;
          end
        end
      end
    end else if (m_wait) begin
      if (ch_ready) begin
        e_launch = 1'b1; m_wait = 0; m_hold = HC;
      end
    end else begin
      m_hold--;
      if (m_hold == 0) begin
        m_busy = 0;
        m_ptr = (m_gid + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; en = 1'b1; ch_ready = 1'b1;
    req_b = '0; en_b = 1'b0; ready_b = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ch_ready = 1'b1; req = 4'hF; req_data = '1;
    req_b = 1'b1; en_b = 1'b1; ready_b = 1'b1; data_b = '1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
      checks++; if (ch_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", ch_data); end
      checks++; if (ch_launch !== 1'b0) begin errors++; $display("FAIL reset_launch: got %b want 0", ch_launch); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({ack_b, launch_b, busy_b} !== 3'b0) begin errors++; $display("FAIL reset_b: got %b want 000", {ack_b, launch_b, busy_b}); end
    end
    req = '0; req_b = '0; en_b = 1'b0; rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || ack !== 4'b0) begin errors++; $display("FAIL reset_idle: busy=%b ack=%b want 0/0000", busy, ack); end
  endtask

  task automatic test_single();
    do_reset();
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req = 4'b0100;
    tick();
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1: got %b want 1", busy); end
    checks++; if (ch_launch !== 1'b0) begin errors++; $display("FAIL single_nolaunch1: got %b want 0", ch_launch); end
    req = '0;
    tick();
    checks++; if (ch_launch !== 1'b1 || ack !== 4'b0) begin errors++; $display("FAIL single_launch: launch=%b ack=%b want 1/0000", ch_launch, ack); end
    for (int c = 3; c <= 4; c++) begin
      tick();
      checks++; if (ch_data !== 32'hDEADBEEF || busy !== 1'b1 || ch_launch !== 1'b0) begin
        errors++; $display("FAIL single_hold c%0d: data=%h busy=%b launch=%b want deadbeef/1/0", c, ch_data, busy, ch_launch);
      end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy5: got %b want 0", busy); end
    checks++; if (ch_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data5: got %h want deadbeef", ch_data); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_gid: got %0d want 2", grant_id); end
  endtask

  task automatic test_fairness();
    int order[$];
    int lt[$];
    do_reset();
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = $urandom;
    req = 4'hF;
    for (int c = 0; c < 80 && (order.size() < 5 || lt.size() < 5); c++) begin
      tick();
      if (ack != '0) begin
        for (int k = 0; k < N; k++) if (ack[k]) order.push_back(k);
        req = req & ~ack;
      end else begin
        req = 4'hF;
      end
      if (ch_launch) lt.push_back(cyc);
    end
    req = '0;
    checks++;
    if (order.size() < 5 || lt.size() < 5) begin
      errors++; $display("FAIL fair_timeout: grants=%0d launches=%0d want 5/5", order.size(), lt.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (order[i] != i % N) begin errors++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, order[i], i % N); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++; if (lt[i] - lt[i-1] != HC + 2) begin errors++; $display("FAIL fair_spacing[%0d]: got %0d want %0d", i, lt[i] - lt[i-1], HC + 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] v;
    do_reset();
    v = $urandom;
    req_data[0 +: DW] = v;
    ch_ready = 1'b0;
    req = 4'b0001;
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL bp_ack: got %b want 0001", ack); end
    req = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (ch_launch !== 1'b0 || busy !== 1'b1 || ch_data !== v) begin
        errors++; $display("FAIL bp_stall c%0d: launch=%b busy=%b data=%h want 0/1/%h", c, ch_launch, busy, ch_data, v);
      end
    end
    ch_ready = 1'b1;
    tick();
    checks++; if (ch_launch !== 1'b1) begin errors++; $display("FAIL bp_launch: got %b want 1", ch_launch); end
  endtask

  task automatic test_en_gating();
    do_reset();
    en = 1'b0;
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (ack !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_block c%0d: ack=%b busy=%b want 0000/0", c, ack, busy); end
    end
    en = 1'b1;
    tick();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL en_ack: got %b want 0001", ack); end
    req = '0;
    tick();
    checks++; if (ch_launch !== 1'b1) begin errors++; $display("FAIL en_launch: got %b want 1", ch_launch); end
    en = 1'b0;
    req = 4'b0010;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_holddone: busy=%b want 0", busy); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (ack !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL en_park c%0d: ack=%b busy=%b want 0000/0", c, ack, busy); end
    end
    en = 1'b1;
    tick();
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL en_resume: got %b want 0010", ack); end
    req = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (4) tick();
    req = 4'b0001;
    tick();
    req = '0;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++; if (ack !== 4'b0 || ch_launch !== 1'b0 || busy !== 1'b0 || ch_data !== '0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rstmid_outs: ack=%b launch=%b busy=%b data=%h gid=%0d want all 0", ack, ch_launch, busy, ch_data, grant_id);
    end
    rst = 1'b0;
    req = 4'b1010;
    tick();
    checks++; if (ack !== 4'b0010 || ch_launch !== 1'b0) begin errors++; $display("FAIL rstmid_ptr: ack=%b launch=%b want 0010/0", ack, ch_launch); end
    req = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL rstmid_fresh: got %b want 1000", ack); end
    req = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (4) tick();
    req = 4'b1001;
    tick();
    checks++; if (ack !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("FAIL wrap_first: ack=%b gid=%0d want 1000/3", ack, grant_id); end
    req = 4'b0001;
    repeat (4) tick();
    tick();
    checks++; if (ack !== 4'b0001 || grant_id !== 2'd0) begin errors++; $display("FAIL wrap_second: ack=%b gid=%0d want 0001/0", ack, grant_id); end
    req = '0;
  endtask

  task automatic test_degenerate();
    int lt[$];
    logic [DW-1:0] v;
    do_reset();
    v = $urandom;
    data_b = v;
    en_b = 1'b1; ready_b = 1'b1; req_b = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (launch_b) lt.push_back(cyc);
    end
    checks++; if (gid_b !== 1'b0 || ch_data_b !== v) begin errors++; $display("FAIL degen_state: gid=%0d data=%h want 0/%h", gid_b, ch_data_b, v); end
    checks++;
    if (lt.size() < 5) begin
      errors++; $display("FAIL degen_count: launches=%0d want >=5", lt.size());
    end else begin
      for (int i = 1; i < lt.size(); i++) begin
        checks++; if (lt[i] - lt[i-1] != 3) begin errors++; $display("FAIL degen_spacing[%0d]: got %0d want 3", i, lt[i] - lt[i-1]); end
      end
    end
    req_b = '0; en_b = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] just_acked;
    do_reset();
    just_acked = '0;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(9) != 0);
      ch_ready = ($urandom_range(9) < 6);
      for (int k = 0; k < N; k++) begin
        if (!req[k] && !just_acked[k] && $urandom_range(3) == 0) begin
          req[k] = 1'b1;
          req_data[k*DW +: DW] = $urandom;
        end
      end
      tick();
      checks++; if (ack !== e_ack) begin errors++; $display("FAIL rnd_ack c%0d: got %b want %b", c, ack, e_ack); end
      checks++; if (ch_launch !== e_launch) begin errors++; $display("FAIL rnd_launch c%0d: got %b want %b", c, ch_launch, e_launch); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy); end
      checks++; if (grant_id !== 2'(m_gid)) begin errors++; $display("FAIL rnd_gid c%0d: got %0d want %0d", c, grant_id, m_gid); end
      checks++; if (ch_data !== m_data) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, ch_data, m_data); end
      req = req & ~e_ack;
      just_acked = e_ack;
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ch_ready = 1'b0; req = '0; req_data = '0;
    en_b = 1'b0; ready_b = 1'b0; req_b = '0; data_b = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_en_gating();
    test_reset_mid();
    test_wrap();
    test_degenerate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
